// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared CPU encodings for writeback source, load size and FSM states.
package writeback_unit_pkg;
    localparam logic [1:0] WB_MEM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;
    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;
    localparam logic [1:0] LD_RSVD = 2'b11;
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;
    // Reserved size behaves as a word, so it carries the word alignment rule.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == LD_WORD || size == LD_RSVD) ? |lo : (size == LD_HALF) ? lo[0] : 1'b0;
    endfunction
endpackage

// File: rtl/writeback_unit_load_extend.sv
// load_extend: selects the loaded byte/half lane and zero- or sign-extends it.
module load_extend
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sign_b;
    logic        sign_h;
    always_comb begin
        lane_b = rdata[{addr_lo, 3'b000} +: 8];
        lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
        sign_b = ~ld_unsigned & lane_b[7];
        sign_h = ~ld_unsigned & lane_h[15];
        data   = (ld_size == LD_BYTE) ? {{(DATA_W-8){sign_b}}, lane_b} :
                 (ld_size == LD_HALF) ? {{(DATA_W-16){sign_h}}, lane_h} : rdata;
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: selects writeback data, waits for load responses and drives the register-file write port.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reg_write,
    input  logic [1:0]        wb_sel,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] link,
    input  logic [DATA_W-1:0] imm,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [1:0]        addr_lo,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              err_misalign,
    output logic              err_timeout
);
    logic [0:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic [REG_AW-1:0] lwaddr_q, lwaddr_d;
    logic              lwe_q, lwe_d;
    logic [1:0]        lsize_q, lsize_d;
    logic              luns_q, luns_d;
    logic [1:0]        llo_q, llo_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              err_mis_q, err_mis_d;
    logic              err_to_q, err_to_d;
    logic [DATA_W-1:0] sel_data, ext_data;
    logic              wr;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata       (mem_rdata),
        .ld_size     (lsize_q),
        .ld_unsigned (luns_q),
        .addr_lo     (llo_q),
        .data        (ext_data)
    );

    always_comb begin
        sel_data   = (wb_sel == WB_ALU) ? result : (wb_sel == WB_LINK) ? link : imm;
        cnt_inc    = cnt_q + 8'd1;
        state_d    = state_q;
        cnt_d      = cnt_q;
        lwaddr_d   = lwaddr_q;
        lwe_d      = lwe_q;
        lsize_d    = lsize_q;
        luns_d     = luns_q;
        llo_d      = llo_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_mis_d  = 1'b0;
        err_to_d   = 1'b0;
        wr         = 1'b0;
        // Address/data only move on a real write so they hold across idle cycles.
        if (state_q == ST_IDLE) begin
            if (in_valid && wb_sel != WB_MEM) begin
                wr         = reg_write && (waddr != '0);
                rf_we_d    = wr;
                rf_waddr_d = wr ? waddr : rf_waddr_q;
                rf_wdata_d = wr ? sel_data : rf_wdata_q;
            end else if (in_valid && misaligned(ld_size, addr_lo)) begin
                err_mis_d = 1'b1;
            end else if (in_valid) begin
                lwaddr_d = waddr;
                lwe_d    = reg_write;
                lsize_d  = ld_size;
                luns_d   = ld_unsigned;
                llo_d    = addr_lo;
                cnt_d    = 8'd0;
                state_d  = ST_WAIT_MEM;
            end
        end else if (mem_rvalid) begin
            wr         = lwe_q && (lwaddr_q != '0);
            rf_we_d    = wr;
            rf_waddr_d = wr ? lwaddr_q : rf_waddr_q;
            rf_wdata_d = wr ? ext_data : rf_wdata_q;
            state_d    = ST_IDLE;
        end else begin
            cnt_d    = cnt_inc;
            err_to_d = (cnt_inc == 8'(MEM_TIMEOUT));
            state_d  = err_to_d ? ST_IDLE : ST_WAIT_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lwaddr_q   <= '0;
            lwe_q      <= 1'b0;
            lsize_q    <= '0;
            luns_q     <= 1'b0;
            llo_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_mis_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lwaddr_q   <= lwaddr_d;
            lwe_q      <= lwe_d;
            lsize_q    <= lsize_d;
            luns_q     <= luns_d;
            llo_q      <= llo_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_mis_q  <= err_mis_d;
            err_to_q   <= err_to_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign err_misalign = err_mis_q;
    assign err_timeout  = err_to_q;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks of writeback selection, load extension, errors and reset.
module tb_writeback_unit;
    logic        clk, rst_n, in_valid, in_ready, reg_write, ld_unsigned, mem_rvalid;
    logic [1:0]  wb_sel, ld_size, addr_lo;
    logic [4:0]  waddr, rf_waddr;
    logic [31:0] result, link, imm, mem_rdata, rf_wdata;
    logic        rf_we, err_misalign, err_timeout;
    int          checks = 0;
    int          errors = 0;

    writeback_unit #(.DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .reg_write(reg_write), .wb_sel(wb_sel), .waddr(waddr), .result(result),
        .link(link), .imm(imm), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .addr_lo(addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue_load(input logic [1:0] sz, input logic [1:0] lo, input logic u, input logic [4:0] wa);
        in_valid = 1'b1; reg_write = 1'b1; wb_sel = 2'b00;
        ld_size = sz; addr_lo = lo; ld_unsigned = u; waddr = wa;
        step();
        in_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd, input int waits);
        repeat (waits - 1) step();
        mem_rvalid = 1'b1; mem_rdata = rd;
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; reg_write = 1'b0; wb_sel = 2'b00; waddr = '0;
        result = 32'h0000_1234; link = 32'h0000_0104; imm = 32'h0000_0ABC;
        ld_size = 2'b00; ld_unsigned = 1'b0; addr_lo = 2'b00; mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_emis", err_misalign, 0);
        chk("rst_eto", err_timeout, 0);
        rst_n = 1'b1;
        chk("post_rst_ready", in_ready, 1);

        in_valid = 1'b1; reg_write = 1'b1; wb_sel = 2'b01; waddr = 5'd5;
        step();
        chk("alu_we", rf_we, 1);
        chk("alu_waddr", rf_waddr, 5);
        chk("alu_wdata", rf_wdata, 32'h0000_1234);
        wb_sel = 2'b10; waddr = 5'd7;
        step();
        chk("link_we", rf_we, 1);
        chk("link_waddr", rf_waddr, 7);
        chk("link_wdata", rf_wdata, 32'h0000_0104);
        wb_sel = 2'b11; waddr = 5'd9; reg_write = 1'b0;
        step();
        chk("imm_nowr_we", rf_we, 0);
        chk("imm_hold_waddr", rf_waddr, 7);
        chk("imm_hold_wdata", rf_wdata, 32'h0000_0104);
        reg_write = 1'b1;
        step();
        chk("imm_we", rf_we, 1);
        chk("imm_wdata", rf_wdata, 32'h0000_0ABC);
        in_valid = 1'b0;
        step();
        chk("idle_we", rf_we, 0);

        issue_load(2'b00, 2'b11, 1'b0, 5'd3);
        chk("sb_ready0", in_ready, 0);
        step();
        chk("sb_ready1", in_ready, 0);
        step();
        chk("sb_ready2", in_ready, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
        step();
        mem_rvalid = 1'b0;
        chk("sb_we", rf_we, 1);
        chk("sb_waddr", rf_waddr, 3);
        chk("sb_wdata", rf_wdata, 32'hFFFF_FF80);
        chk("sb_ready3", in_ready, 1);

        issue_load(2'b01, 2'b10, 1'b1, 5'd4);
        respond(32'h8001_1234, 1);
        chk("uh_wdata", rf_wdata, 32'h0000_8001);
        issue_load(2'b01, 2'b00, 1'b0, 5'd4);
        respond(32'h1234_9ABC, 2);
        chk("sh_wdata", rf_wdata, 32'hFFFF_9ABC);
        issue_load(2'b00, 2'b01, 1'b1, 5'd6);
        respond(32'h0000_F600, 1);
        chk("ub_wdata", rf_wdata, 32'h0000_00F6);
        chk("ub_waddr", rf_waddr, 6);
        issue_load(2'b11, 2'b00, 1'b0, 5'd8);
        respond(32'hCAFE_F00D, 1);
        chk("rsvd_wdata", rf_wdata, 32'hCAFE_F00D);

        issue_load(2'b01, 2'b01, 1'b0, 5'd2);
        chk("mish_emis", err_misalign, 1);
        chk("mish_we", rf_we, 0);
        chk("mish_ready", in_ready, 1);
        step();
        chk("mish_pulse", err_misalign, 0);
        issue_load(2'b10, 2'b10, 1'b0, 5'd2);
        chk("misw_emis", err_misalign, 1);
        chk("misw_ready", in_ready, 1);
        issue_load(2'b00, 2'b11, 1'b0, 5'd2);
        chk("byte_no_mis", err_misalign, 0);
        respond(32'h7F00_0000, 1);
        chk("byte_pos_wdata", rf_wdata, 32'h0000_007F);

        issue_load(2'b10, 2'b00, 1'b0, 5'd4);
        step(); step(); step();
        chk("to_early", err_timeout, 0);
        chk("to_wait_ready", in_ready, 0);
        step();
        chk("to_eto", err_timeout, 1);
        chk("to_we", rf_we, 0);
        chk("to_ready", in_ready, 1);
        chk("to_hold", rf_wdata, 32'h0000_007F);
        step();
        chk("to_pulse", err_timeout, 0);

        issue_load(2'b10, 2'b00, 1'b0, 5'd4);
        respond(32'h1234_5678, 4);
        chk("race_we", rf_we, 1);
        chk("race_wdata", rf_wdata, 32'h1234_5678);
        chk("race_eto", err_timeout, 0);

        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_we", rf_we, 0);
        chk("idle_rvalid_data", rf_wdata, 32'h1234_5678);

        issue_load(2'b10, 2'b00, 1'b0, 5'd0);
        respond(32'hDEAD_BEEF, 1);
        chk("x0_we", rf_we, 0);
        chk("x0_hold", rf_wdata, 32'h1234_5678);

        issue_load(2'b10, 2'b00, 1'b0, 5'd11);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_waddr", rf_waddr, 0);
        chk("midrst_wdata", rf_wdata, 0);
        chk("midrst_ready", in_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        step();
        rst_n = 1'b1;
        chk("rel_ready", in_ready, 1);
        step();
        mem_rvalid = 1'b0;
        chk("rel_no_write", rf_we, 0);
        chk("rel_wdata", rf_wdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
